fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_out_buf.sv | 34 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, FSM state type and helpers for the fetch unit
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - single-entry valid/ready buffer between fetch and decode
module fetch_out_buf
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    // Flush wins over load; a load while the entry is being consumed simply replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= load_pc;
            out_instr <= load_instr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one outstanding memory read, redirect handling, decode handoff
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic            buf_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // A response arriving in DROP always ends the drop, even alongside a fresh redirect,
    // so the unit can never wait on a response that will not come.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // Requests are gated by rst_n so the bus is quiet while reset is held.
    always_comb begin
        imem_req_valid = 1'b0;
        buf_load       = 1'b0;
        if (rst_n && (state == ST_REQ) && (!id_valid || id_ready) && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end
        if ((state == ST_WAIT) && imem_rsp_valid && !redirect_valid) begin
            buf_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= align_word(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_word(redirect_pc);
        end else if (buf_load) begin
            pc <= pc + 32'd4;
        end
    end

    assign imem_req_addr = pc;

    fetch_out_buf u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .load       (buf_load),
        .load_pc    (pc),
        .load_instr (imem_rsp_data),
        .out_ready  (id_ready),
        .out_valid  (id_valid),
        .out_pc     (id_pc),
        .out_instr  (id_instr)
    );

    assign id_opcode = id_instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory and decode reference model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: at most one outstanding read, random latency, stale marking on redirect
    bit          mem_out;
    bit          mem_stale;
    bit          rsp_now;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_min = 1;
    int          lat_max = 1;
    // decode-side view: delivered-but-unconsumed instructions and the next fetch address
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] fetch_addr;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[3:2])
            2'd0:    op = 7'b0110011;
            2'd1:    op = 7'b0000011;
            2'd2:    op = 7'b0100011;
            default: op = 7'b1100011;
        endcase
        return {a[31:7] ^ 25'h15A5A5A, op};
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
    endtask

    task automatic model_clear();
        mem_out    = 1'b0;
        mem_stale  = 1'b0;
        rsp_now    = 1'b0;
        q_pc.delete();
        q_instr.delete();
        fetch_addr = RST_PC;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic drive_cycle(input bit idr, input bit mrdy, input bit rv,
                               input logic [31:0] rpc, input bit spur);
        @(negedge clk);
        id_ready       = idr;
        imem_req_ready = mrdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rsp_now        = mem_out && (mem_cnt == 1);
        imem_rsp_valid = rsp_now || (spur && !mem_out);
        imem_rsp_data  = rsp_now ? mem_word(mem_addr) : $urandom;
        #1;
    endtask

    task automatic commit();
        if (id_valid && id_ready && q_pc.size() > 0) begin
            void'(q_pc.pop_front());
            void'(q_instr.pop_front());
        end
        if (mem_out) begin
            if (rsp_now) begin
                mem_out = 1'b0;
                if (!mem_stale && !redirect_valid) begin
                    q_pc.push_back(mem_addr);
                    q_instr.push_back(mem_word(mem_addr));
                    fetch_addr = mem_addr + 32'd4;
                end
            end else begin
                mem_cnt--;
            end
        end
        if (redirect_valid) begin
            q_pc.delete();
            q_instr.delete();
            fetch_addr = {redirect_pc[31:2], 2'b00};
            if (mem_out) mem_stale = 1'b1;
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_out   = 1'b1;
            mem_addr  = imem_req_addr;
            mem_cnt   = $urandom_range(lat_max, lat_min);
            mem_stale = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        n_tests++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", id_instr); end
        n_tests++; if (id_opcode !== 7'h0) begin n_fail++; $display("FAIL reset_id_opcode: got %h want 0", id_opcode); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        #1;
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL first_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 7; c++) begin
            drive_cycle(1, 1, 0, 32'h0, 0);
            n_tests++; if (imem_req_valid !== (c % 2 == 0)) begin n_fail++; $display("FAIL seq_req_valid c%0d: got %b want %b", c, imem_req_valid, (c % 2 == 0)); end
            if (c % 2 == 0) begin
                n_tests++; if (imem_req_addr !== 32'(c * 2)) begin n_fail++; $display("FAIL seq_req_addr c%0d: got %h want %h", c, imem_req_addr, 32'(c * 2)); end
            end
            n_tests++; if (id_valid !== (c >= 2 && c % 2 == 0)) begin n_fail++; $display("FAIL seq_id_valid c%0d: got %b want %b", c, id_valid, (c >= 2 && c % 2 == 0)); end
            if (c >= 2 && c % 2 == 0) begin
                n_tests++; if (id_pc !== 32'((c - 2) * 2)) begin n_fail++; $display("FAIL seq_id_pc c%0d: got %h want %h", c, id_pc, 32'((c - 2) * 2)); end
                n_tests++; if (id_instr !== mem_word(32'((c - 2) * 2))) begin n_fail++; $display("FAIL seq_id_instr c%0d: got %h want %h", c, id_instr, mem_word(32'((c - 2) * 2))); end
            end
            commit();
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(0, 1, 0, 32'h0, 0);
            commit();
        end
        for (int c = 2; c < 7; c++) begin
            drive_cycle(0, 1, 0, 32'h0, 0);
            n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_id_valid c%0d: got %b want 1", c, id_valid); end
            n_tests++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_id_pc c%0d: got %h want 0", c, id_pc); end
            n_tests++; if (id_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL stall_id_instr c%0d: got %h want %h", c, id_instr, mem_word(32'h0)); end
            n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid c%0d: got %b want 0", c, imem_req_valid); end
            commit();
        end
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL release_req_addr: got %h want 4", imem_req_addr); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL release_consumed: got %b want 0", id_valid); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_pc !== 32'h4 || id_valid !== 1'b1) begin n_fail++; $display("FAIL release_next_pc: got %h/%b want 4/1", id_pc, id_valid); end
        commit();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        lat_min = 3; lat_max = 3;
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 1, 32'h0000_0103, 0);
        commit();
        lat_min = 1; lat_max = 1;
        for (int c = 2; c < 4; c++) begin
            drive_cycle(1, 1, 0, 32'h0, 0);
            n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drop_req_valid c%0d: got %b want 0", c, imem_req_valid); end
            n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drop_id_valid c%0d: got %b want 0", c, id_valid); end
            commit();
        end
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drop_stale_shown: got %b want 0", id_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_req: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL drop_target_instr: got %h/%h want 00000100/%h", id_pc, id_instr, mem_word(32'h100)); end
        commit();
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 1, 32'h0000_0200, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_id_valid: got %b want 0", id_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL coinc_next_req: got %b/%h want 1/00000200", imem_req_valid, imem_req_addr); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_pc !== 32'h200 || id_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_target_pc: got %h/%b want 00000200/1", id_pc, id_valid); end
        commit();
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 1, 1, 32'hFFFF_FFFE, 0);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect_req: got %b want 0", imem_req_valid); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (imem_req_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_top_req: got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        n_tests++; if (id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id_pc: got %h want fffffffc", id_pc); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        commit();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] w;
        do_reset();
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 1, 1, 32'h0000_0040, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        lat_min = 3; lat_max = 3;
        drive_cycle(1, 1, 0, 32'h0, 0);
        commit();
        drive_cycle(0, 1, 0, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_id_valid: got %b want 0", id_valid); end
        n_tests++; if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_opcode !== 7'h0) begin n_fail++; $display("FAIL midreset_id_regs: got %h/%h/%h want 0/0/0", id_pc, id_instr, id_opcode); end
        idle_inputs();
        model_clear();
        lat_min = 1; lat_max = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 11; c++) begin
            drive_cycle(1, 1, 0, 32'h0, 0);
            if (c == 0) begin
                n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL restart_req: got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
            end
            if (c >= 2 && c % 2 == 0) begin
                w = mem_word(32'((c - 2) * 2));
                n_tests++; if (id_pc !== 32'((c - 2) * 2)) begin n_fail++; $display("FAIL restart_id_pc c%0d: got %h want %h", c, id_pc, 32'((c - 2) * 2)); end
                n_tests++; if (id_opcode !== w[6:0]) begin n_fail++; $display("FAIL opcode c%0d: got %b want %b", c, id_opcode, w[6:0]); end
            end
            commit();
        end
    endtask

    task automatic test_random();
        bit          idr, mrdy, rv, spur, exp_req;
        logic [31:0] rpc;
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            idr  = ($urandom_range(0, 99) < 70);
            mrdy = ($urandom_range(0, 99) < 70);
            rv   = ($urandom_range(0, 99) < 6);
            spur = ($urandom_range(0, 99) < 10);
            rpc  = $urandom;
            drive_cycle(idr, mrdy, rv, rpc, spur);
            exp_req = !mem_out && (q_pc.size() == 0 || idr) && !rv;
            n_tests++; if (imem_req_valid !== exp_req) begin n_fail++; $display("FAIL rnd_req_valid c%0d: got %b want %b", c, imem_req_valid, exp_req); end
            if (imem_req_valid === 1'b1) begin
                n_tests++; if (imem_req_addr !== fetch_addr) begin n_fail++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, imem_req_addr, fetch_addr); end
            end
            n_tests++; if (id_valid !== (q_pc.size() != 0)) begin n_fail++; $display("FAIL rnd_id_valid c%0d: got %b want %b", c, id_valid, (q_pc.size() != 0)); end
            if (id_valid === 1'b1 && q_pc.size() != 0) begin
                n_tests++; if (id_pc !== q_pc[0] || id_instr !== q_instr[0]) begin n_fail++; $display("FAIL rnd_id_data c%0d: got %h/%h want %h/%h", c, id_pc, id_instr, q_pc[0], q_instr[0]); end
                n_tests++; if (id_opcode !== q_instr[0][6:0]) begin n_fail++; $display("FAIL rnd_opcode c%0d: got %b want %b", c, id_opcode, q_instr[0][6:0]); end
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
